// File: rtl/led_pattern_seq_pkg.sv
// Shared mode encoding and direction constants for the LED pattern sequencer.
package led_pattern_seq_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF    = 2'b00;
  localparam mode_t MODE_SHIFT  = 2'b01;
  localparam mode_t MODE_BOUNCE = 2'b10;
  localparam mode_t MODE_COUNT  = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_pattern_seq_btn_debounce.sv
// Button synchroniser plus counter-based debouncer; emits a single-cycle pulse
// when the accepted level goes from 0 to 1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;  // release is deliberately silent
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_pattern_seq.sv
// LED output stage: each tick_in edge steps the pattern of the current mode,
// and debounced button presses cycle through the four modes.
module led_pattern_seq
  import led_pattern_seq_pkg::*;
#(
  parameter int NUM_LEDS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_in,
  input  logic                btn_mode,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode
);

  localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);

  logic                tick1_q, tick2_q, tick_hist_q;
  logic                step;
  logic                press;
  logic [NUM_LEDS-1:0] led_q, led_d;
  mode_t               mode_q, mode_d;
  logic                dir_q, dir_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_mode),
    .press_o(press)
  );

  assign step = tick2_q ^ tick_hist_q;

  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    dir_d  = dir_q;
    if (press) begin
      // A coincident step is dropped: the new mode starts from its initial pattern.
      mode_d = mode_t'(mode_q + 2'd1);
      case (mode_d)
        MODE_SHIFT:  led_d = LED_ONE;
        MODE_BOUNCE: begin
          led_d = LED_ONE;
          dir_d = DIR_LEFT;
        end
        default:     led_d = '0;
      endcase
    end else if (step) begin
      case (mode_q)
        MODE_SHIFT:  led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
        MODE_BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            led_d = led_q << 1;
            if (led_q[NUM_LEDS-2]) dir_d = DIR_RIGHT;
          end else begin
            led_d = led_q >> 1;
            if (led_q[1]) dir_d = DIR_LEFT;
          end
        end
        MODE_COUNT:  led_d = led_q + LED_ONE;
        default:     led_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick1_q     <= 1'b0;
      tick2_q     <= 1'b0;
      tick_hist_q <= 1'b0;
      led_q       <= '0;
      mode_q      <= MODE_OFF;
      dir_q       <= DIR_LEFT;
    end else begin
      tick1_q     <= tick_in;
      tick2_q     <= tick1_q;
      tick_hist_q <= tick2_q;
      led_q       <= led_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule
